// File: rtl/pipe_decode_sb.sv
// Decode-stage register file with per-register outstanding-write scoreboard,
// writeback forwarding and optional HI/LO pair.
`default_nettype none

module pipe_decode_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 2,
  parameter int BYPASS  = 1,
  parameter int HILO_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_retire,
  input  logic              hilo_wr,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              stall,
  output logic              issue_err
);

  localparam int              NREG     = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic [NREG-1:0][DATA_W-1:0] regs_q;
  logic [NREG-1:0][CNT_W-1:0]  pend_q, pend_d;
  logic                        err_q, err_d;

  logic wb_ok, retire_ok, issue_ok, same_reg, issue_full;
  logic rs_byp, rt_byp, rs_haz, rt_haz;

  assign wb_ok     = wb_en && (wb_addr != '0);
  assign retire_ok = wb_ok && wb_retire;
  assign issue_ok  = issue_valid && (issue_dst != '0);
  assign same_reg  = issue_ok && retire_ok && (issue_dst == wb_addr);
  // A same-cycle retire to a saturated destination makes room, so it is not full.
  assign issue_full = issue_valid && (pend_q[issue_dst] == PEND_MAX) &&
                      !(retire_ok && (wb_addr == issue_dst));

  assign rs_byp = (BYPASS != 0) && wb_ok && (wb_addr == rs_addr);
  assign rt_byp = (BYPASS != 0) && wb_ok && (wb_addr == rt_addr);

  always_comb begin
    read_data_1 = '0;
    read_data_2 = '0;
    if (rs_addr != '0) read_data_1 = rs_byp ? wb_data : regs_q[rs_addr];
    if (rt_addr != '0) read_data_2 = rt_byp ? wb_data : regs_q[rt_addr];
  end

  assign rs_haz = rs_used && (pend_q[rs_addr] != '0) && !(rs_byp && wb_retire);
  assign rt_haz = rt_used && (pend_q[rt_addr] != '0) && !(rt_byp && wb_retire);
  assign stall  = reset && (rs_haz || rt_haz || issue_full);

  always_comb begin
    pend_d = pend_q;
    if (issue_ok && !same_reg && (pend_q[issue_dst] != PEND_MAX))
      pend_d[issue_dst] = pend_q[issue_dst] + PEND_ONE;
    if (retire_ok && !same_reg && (pend_q[wb_addr] != '0))
      pend_d[wb_addr] = pend_q[wb_addr] - PEND_ONE;
    pend_d[0] = '0;
    err_d = err_q || (issue_ok && issue_full);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (wb_ok) regs_q[wb_addr] <= wb_data;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign issue_err = err_q;

  generate
    if (HILO_EN != 0) begin : g_hilo
      logic [DATA_W-1:0] hi_q, lo_q;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          hi_q <= '0;
          lo_q <= '0;
        end else if (hilo_wr) begin
          hi_q <= hi_in;
          lo_q <= lo_in;
        end
      end

      assign hi_out = ((BYPASS != 0) && hilo_wr && reset) ? hi_in : hi_q;
      assign lo_out = ((BYPASS != 0) && hilo_wr && reset) ? lo_in : lo_q;
    end else begin : g_no_hilo
      assign hi_out = '0;
      assign lo_out = '0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pipe_decode_sb.sv
// Directed self-checking bench for pipe_decode_sb (default parameters).
`default_nettype none

module tb_pipe_decode_sb;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  rs_addr, rt_addr, issue_dst, wb_addr;
  logic        rs_used, rt_used, issue_valid, wb_en, wb_retire, hilo_wr;
  logic [31:0] wb_data, hi_in, lo_in;
  logic [31:0] read_data_1, read_data_2, hi_out, lo_out;
  logic        stall, issue_err;

  int errors = 0;
  int checks = 0;

  pipe_decode_sb dut (
    .clock       (clock),
    .reset       (reset),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .rs_used     (rs_used),
    .rt_used     (rt_used),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .issue_valid (issue_valid),
    .issue_dst   (issue_dst),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .wb_retire   (wb_retire),
    .hilo_wr     (hilo_wr),
    .hi_in       (hi_in),
    .lo_in       (lo_in),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .stall       (stall),
    .issue_err   (issue_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_wb();
    wb_en = 1'b0; wb_retire = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  initial begin
    reset = 1'b0;
    rs_addr = '0; rt_addr = '0; rs_used = 1'b0; rt_used = 1'b0;
    issue_valid = 1'b0; issue_dst = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_retire = 1'b0;
    hilo_wr = 1'b0; hi_in = '0; lo_in = '0;
    #3;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_err",   {31'b0, issue_err}, 32'h0);
    chk("rst_hi",    hi_out, 32'h0);
    chk("rst_lo",    lo_out, 32'h0);
    #9 reset = 1'b1;
    tick();

    // Plain write then read; write to r0 is discarded.
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678;
    tick();
    idle_wb(); rs_addr = 5'd5;
    #1 chk("rd_r5", read_data_1, 32'h1234_5678);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF; rs_addr = 5'd0;
    #1 chk("r0_byp", read_data_1, 32'h0);
    tick();
    idle_wb();
    #1 chk("r0_after", read_data_1, 32'h0);

    // Same-cycle forwarding on read port 2.
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5_A5A5; rt_addr = 5'd7;
    #1 chk("byp_rt", read_data_2, 32'hA5A5_A5A5);
    tick();
    idle_wb();
    #1 chk("r7_stored", read_data_2, 32'hA5A5_A5A5);

    // Issue r3, stall while pending, release in retire cycle.
    issue_valid = 1'b1; issue_dst = 5'd3;
    tick();
    issue_valid = 1'b0; rs_addr = 5'd3; rs_used = 1'b0;
    #1 chk("r3_unused", {31'b0, stall}, 32'h0);
    rs_used = 1'b1;
    #1 chk("r3_stall0", {31'b0, stall}, 32'h1);
    tick();
    chk("r3_stall1", {31'b0, stall}, 32'h1);
    wb_en = 1'b1; wb_retire = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    #1 chk("r3_ret_stall", {31'b0, stall}, 32'h0);
    chk("r3_ret_data", read_data_1, 32'hDEAD_BEEF);
    tick();
    idle_wb();
    #1 chk("r3_clear", {31'b0, stall}, 32'h0);
    chk("r3_data", read_data_1, 32'hDEAD_BEEF);
    rs_used = 1'b0;

    // Saturate r4 (pend=3), fourth issue dropped with sticky error.
    issue_valid = 1'b1; issue_dst = 5'd4;
    tick(); tick(); tick();
    #1 chk("sat_stall", {31'b0, stall}, 32'h1);
    chk("sat_err_pre", {31'b0, issue_err}, 32'h0);
    tick();
    issue_valid = 1'b0;
    #1 chk("sat_err", {31'b0, issue_err}, 32'h1);
    chk("sat_nostall", {31'b0, stall}, 32'h0);
    rs_addr = 5'd4; rs_used = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wb_en = 1'b1; wb_retire = 1'b1; wb_addr = 5'd4; wb_data = 32'h40 + k;
      tick();
      idle_wb();
      #1 chk($sformatf("sat_ret%0d", k), {31'b0, stall}, (k < 2) ? 32'h1 : 32'h0);
    end
    rs_used = 1'b0;

    // Issue and retire r9 together while pend=1: net zero.
    issue_valid = 1'b1; issue_dst = 5'd9;
    tick();
    wb_en = 1'b1; wb_retire = 1'b1; wb_addr = 5'd9; wb_data = 32'h9999_0000;
    tick();
    issue_valid = 1'b0; idle_wb();
    rs_addr = 5'd9; rs_used = 1'b1;
    #1 chk("r9_pend1", {31'b0, stall}, 32'h1);
    chk("r9_data", read_data_1, 32'h9999_0000);
    wb_en = 1'b1; wb_retire = 1'b1; wb_addr = 5'd9; wb_data = 32'h9999_0001;
    tick();
    idle_wb();
    #1 chk("r9_pend0", {31'b0, stall}, 32'h0);
    rs_used = 1'b0;

    // HI/LO forwarding and update, alongside a regular write.
    hilo_wr = 1'b1; hi_in = 32'h1; lo_in = 32'h2;
    wb_en = 1'b1; wb_addr = 5'd12; wb_data = 32'hC0DE_0012;
    #1 chk("hi_byp", hi_out, 32'h1);
    chk("lo_byp", lo_out, 32'h2);
    tick();
    hilo_wr = 1'b0; hi_in = '0; lo_in = '0; idle_wb();
    rt_addr = 5'd12;
    #1 chk("hi_q", hi_out, 32'h1);
    chk("lo_q", lo_out, 32'h2);
    chk("r12", read_data_2, 32'hC0DE_0012);

    // Mid-stream reset with r3 pending and error flag set.
    issue_valid = 1'b1; issue_dst = 5'd3;
    tick();
    issue_valid = 1'b0; rs_addr = 5'd3; rs_used = 1'b1;
    #1 chk("pre_rst_stall", {31'b0, stall}, 32'h1);
    #1 reset = 1'b0;
    #1 chk("mid_rst_stall", {31'b0, stall}, 32'h0);
    chk("mid_rst_rd1", read_data_1, 32'h0);
    chk("mid_rst_rd2", read_data_2, 32'h0);
    chk("mid_rst_hi", hi_out, 32'h0);
    chk("mid_rst_lo", lo_out, 32'h0);
    chk("mid_rst_err", {31'b0, issue_err}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("post_rst_stall", {31'b0, stall}, 32'h0);
    chk("post_rst_err", {31'b0, issue_err}, 32'h0);
    rs_used = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_decode_sb.md
PIPE_DECODE_SB -- requirements
Module: pipe_decode_sb

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; the file has 2**ADDR_W entries.
- CNT_W, 2, width of each per-register outstanding-write counter.
- BYPASS, 1, when 1, same-cycle write data is forwarded to the read ports.
- HILO_EN, 1, when 1, HI/LO registers are implemented; when 0, hi_out and lo_out are tied to 0.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clock, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, asynchronous, active-low.
- rs_addr, in, ADDR_W, read port 1 address.
- rt_addr, in, ADDR_W, read port 2 address.
- rs_used, in, 1, read port 1 participates in the hazard check.
- rt_used, in, 1, read port 2 participates in the hazard check.
- read_data_1, out, DATA_W, read port 1 data.
- read_data_2, out, DATA_W, read port 2 data.
- issue_valid, in, 1, a long-latency write to issue_dst is issued this cycle.
- issue_dst, in, ADDR_W, destination of the issued write.
- wb_en, in, 1, writeback strobe.
- wb_addr, in, ADDR_W, writeback address.
- wb_data, in, DATA_W, writeback data.
- wb_retire, in, 1, this writeback retires one outstanding issued write.
- hilo_wr, in, 1, write hi_in and lo_in.
- hi_in, in, DATA_W, HI write data.
- lo_in, in, DATA_W, LO write data.
- hi_out, out, DATA_W, HI value.
- lo_out, out, DATA_W, LO value.
- stall, out, 1, hazard; the upstream stage must hold.
- issue_err, out, 1, sticky flag: issue attempted with the counter saturated.

Function
REQ-003 Reads SHALL be combinational; register 0 SHALL always read 0.
REQ-004 A read SHALL return wb_data when BYPASS=1, wb_en=1, wb_addr equals the read address, and wb_addr is not 0; otherwise it SHALL return the stored entry.
REQ-005 On a clock edge with wb_en=1 and wb_addr not 0, entry[wb_addr] SHALL be updated to wb_data; writes to address 0 SHALL be discarded.
REQ-006 Each register SHALL have a counter pend[r] of width CNT_W; pend[0] SHALL be constantly 0.
REQ-007 When issue_valid=1, issue_dst is not 0, and pend is below its maximum value, pend[issue_dst] SHALL increment by 1.
REQ-008 When wb_en=1, wb_retire=1, and pend[wb_addr] is greater than 0, pend[wb_addr] SHALL decrement by 1.
REQ-009 If an issue and a retire hit the same register in the same cycle, pend SHALL be unchanged (net zero).
REQ-010 An issue to a register whose pend is at maximum, with no same-cycle retire to that register, SHALL be dropped and SHALL set issue_err; issue_err SHALL be cleared only by reset.
REQ-011 A retire when pend is 0 SHALL leave pend at 0; the data write still occurs.
REQ-012 stall SHALL be 1 when any of the following holds:
- rs_used=1 and pend[rs_addr] is greater than 0, and no bypassing retire to rs_addr occurs this cycle;
- the same condition for rt;
- issue_valid=1 with pend[issue_dst] at maximum and no same-cycle retire to issue_dst.
REQ-013 stall SHALL be combinational, with zero-cycle latency from its inputs.
REQ-014 HI/LO (HILO_EN=1): on hilo_wr, hi and lo SHALL both update on the edge.
REQ-015 With BYPASS=1, hi_out and lo_out SHALL show hi_in and lo_in during a cycle with hilo_wr=1.
REQ-016 The write counter and the HI/LO registers SHALL be independent of each other; simultaneous wb, issue and hilo_wr SHALL all take effect.

Reset
REQ-017 While reset=0, asynchronously, the following SHALL hold regardless of clock:
- all entries = 0;
- all pend = 0;
- hi = 0 and lo = 0;
- issue_err = 0.
REQ-018 While reset=0, stall SHALL read 0.
REQ-019 Reset asserted mid-operation SHALL abandon all outstanding writes; no pending state SHALL survive.
REQ-020 The first state-updating edge SHALL be the first rising clock edge after reset deasserts.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Write r5=0x1234_5678, then read rs_addr=5 on the next cycle -> read_data_1=0x1234_5678; write r0=0xFFFF_FFFF -> r0 reads 0.
- BYPASS=1: wb_en=1, wb_addr=7, wb_data=0xA5A5_A5A5, rt_addr=7 in the same cycle -> read_data_2=0xA5A5_A5A5 before the edge.
- Issue r3, then rs_addr=3 with rs_used=1 -> stall=1 each cycle until a retire to r3; in the retire cycle, stall=0 and read_data_1=wb_data.
- CNT_W=2: issue r4 three times (pend=3), then a fourth issue -> stall=1, issue_err=1, pend stays 3; three retires -> pend=0.
- Issue r9 and retire r9 in the same cycle with pend=1 -> pend stays 1.
- hilo_wr=1, hi_in=0x1, lo_in=0x2 -> hi_out=0x1, lo_out=0x2 in the same cycle and after the edge; then reset low mid-stream -> all outputs 0 immediately, pend cleared.
